alu_seq: RTL and testbench

- Parametrised multi-cycle ALU; next generation of the datapath's single-cycle 32-bit ALU.
- Adds a valid/ready handshake on both sides, an iterative shifter (one bit position per clock), an extended opcode set, and registered Z/N/C/V flags.
- Sits between the decode/register-read stage and the writeback register. Writeback stalls on out_valid.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_comb.sv | 63 ++++++
 rtl/alu_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encodings, FSM state type and helpers shared by the
//               multi-cycle ALU and its combinational core.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_OR  = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [2:0] f_op);
        return (f_op == OP_SLL) || (f_op == OP_SRL) || (f_op == OP_SRA);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Single-cycle ALU ops with Z/N/C/V flags. Shift opcodes pass
//               operand A through (the zero-amount shift case).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zflag,
    output logic             nflag,
    output logic             cflag,
    output logic             vflag
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_add_ovf;
    logic           w_sub_ovf;
    logic           w_less;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: the carry out is the inverted borrow
    assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
    assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    assign w_less    = w_diff[WIDTH-1] ^ w_sub_ovf;

    always_comb begin
        result = a;
        cflag  = 1'b0;
        vflag  = 1'b0;
        case (op)
            OP_OR:  result = a | b;
            OP_AND: result = a & b;
            OP_ADD: begin
                result = w_sum[WIDTH-1:0];
                cflag  = w_sum[WIDTH];
                vflag  = w_add_ovf;
            end
            OP_SUB: begin
                result = w_diff[WIDTH-1:0];
                cflag  = w_diff[WIDTH];
                vflag  = w_sub_ovf;
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, w_less};
            default: result = a;
        endcase
    end

    assign zflag = (result == '0);
    assign nflag = result[WIDTH-1];

endmodule : alu_comb
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle ALU with valid/ready handshakes, a one-bit-per-
//               clock iterative shifter and registered Z/N/C/V flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zflag,
    output logic             nflag,
    output logic             cflag,
    output logic             vflag
);

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_z, r_n, r_c, r_v;

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;
    logic               w_accept;
    logic [WIDTH-1:0]   w_a_shift1;
    logic [WIDTH-1:0]   w_work_shift1;
    logic [WIDTH-1:0]   w_comb_result;
    logic               w_comb_z, w_comb_n, w_comb_c, w_comb_v;

    function automatic logic [WIDTH-1:0] shift1(input logic [2:0] f_op,
                                                input logic [WIDTH-1:0] f_val);
        case (f_op)
            OP_SLL:  return {f_val[WIDTH-2:0], 1'b0};
            OP_SRA:  return {f_val[WIDTH-1], f_val[WIDTH-1:1]};
            default: return {1'b0, f_val[WIDTH-1:1]};
        endcase
    endfunction

    assign w_shamt       = b[SHAMT_W-1:0];
    assign w_is_shift    = is_shift(op);
    assign w_accept      = in_valid && in_ready;
    assign w_a_shift1    = shift1(op, a);
    assign w_work_shift1 = shift1(r_op, r_work);

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (w_comb_result),
        .zflag  (w_comb_z),
        .nflag  (w_comb_n),
        .cflag  (w_comb_c),
        .vflag  (w_comb_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    w_next = (w_is_shift && (w_shamt > SHAMT_W'(1))) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == SHAMT_W'(1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The first shift is taken in the accepting cycle, so the counter holds
    // the shifts still outstanding and latency comes out at max(shamt,1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_OR;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= op;
                        if (w_is_shift && (w_shamt > SHAMT_W'(1))) begin
                            r_work <= w_a_shift1;
                            r_cnt  <= w_shamt - SHAMT_W'(1);
                        end else if (w_is_shift && (w_shamt == SHAMT_W'(1))) begin
                            r_result <= w_a_shift1;
                            r_z      <= (w_a_shift1 == '0);
                            r_n      <= w_a_shift1[WIDTH-1];
                            r_c      <= 1'b0;
                            r_v      <= 1'b0;
                        end else begin
                            r_result <= w_comb_result;
                            r_z      <= w_comb_z;
                            r_n      <= w_comb_n;
                            r_c      <= w_comb_c;
                            r_v      <= w_comb_v;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_work_shift1;
                    r_cnt  <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_result <= w_work_shift1;
                        r_z      <= (w_work_shift1 == '0);
                        r_n      <= w_work_shift1[WIDTH-1];
                        r_c      <= 1'b0;
                        r_v      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign zflag  = r_z;
    assign nflag  = r_n;
    assign cflag  = r_c;
    assign vflag  = r_v;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq: reference model results are
//               queued at issue and compared when out_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] C_OR  = 3'b000;
    localparam logic [2:0] C_ADD = 3'b001;
    localparam logic [2:0] C_SLL = 3'b010;
    localparam logic [2:0] C_SRL = 3'b011;
    localparam logic [2:0] C_SUB = 3'b100;
    localparam logic [2:0] C_AND = 3'b101;
    localparam logic [2:0] C_SLT = 3'b110;
    localparam logic [2:0] C_SRA = 3'b111;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [3:0]  zncv;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zflag, nflag, cflag, vflag;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zflag     (zflag),
        .nflag     (nflag),
        .cflag     (cflag),
        .vflag     (vflag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input string tag, input logic [2:0] f_op,
                                   input logic [31:0] fa, input logic [31:0] fb);
        exp_t        e;
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        int          sh;
        sh = int'(fb[4:0]);
        c  = 1'b0;
        v  = 1'b0;
        case (f_op)
            C_OR:  r = fa | fb;
            C_AND: r = fa & fb;
            C_ADD: begin
                s = {1'b0, fa} + {1'b0, fb};
                r = s[31:0];
                c = s[32];
                v = (fa[31] == fb[31]) && (r[31] != fa[31]);
            end
            C_SUB: begin
                r = fa - fb;
                c = (fa >= fb);
                v = (fa[31] != fb[31]) && (r[31] != fa[31]);
            end
            C_SLT: r = ($signed(fa) < $signed(fb)) ? 32'd1 : 32'd0;
            C_SLL: r = fa << sh;
            C_SRL: r = fa >> sh;
            default: r = $signed(fa) >>> sh;
        endcase
        e.tag  = tag;
        e.res  = r;
        e.zncv = {(r == 32'd0), r[31], c, v};
        e.lat  = ((f_op == C_SLL || f_op == C_SRL || f_op == C_SRA) && sh > 1) ? sh : 1;
        return e;
    endfunction

    // Issue one op, queue its expectation, then scramble the inputs.
    task automatic send(input string tag, input logic [2:0] f_op,
                        input logic [31:0] fa, input logic [31:0] fb);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        sb.push_back(model(tag, f_op, fa, fb));
        in_valid = 1'b1;
        op = f_op;
        a  = fa;
        b  = fb;
        step();
        in_valid = 1'b0;
        op = 3'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic collect();
        exp_t e;
        int   lat = 1;
        while (!out_valid && lat < 64) begin
            step();
            lat++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            check({e.tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        check({e.tag, "_result"},  {32'd0, result}, {32'd0, e.res});
        check({e.tag, "_zncv"},    {60'd0, zflag, nflag, cflag, vflag}, {60'd0, e.zncv});
        check({e.tag, "_latency"}, 64'(lat), 64'(e.lat));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        check({tag, "_out_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_ready_back"},     {63'd0, in_ready},  64'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f_op,
                          input logic [31:0] fa, input logic [31:0] fb);
        send(tag, f_op, fa, fb);
        collect();
        release_result(tag);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b1;
        op        = C_ADD;
        a         = 32'h1234_5678;
        b         = 32'h1;
        out_ready = 1'b1;

        step();
        step();
        check("rst_in_ready",  {63'd0, in_ready},  64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result",    {32'd0, result},    64'd0);
        check("rst_flags",     {60'd0, zflag, nflag, cflag, vflag}, 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        run_op("add_ovf",   C_ADD, 32'h7FFF_FFFF, 32'h1);
        run_op("sub_zero",  C_SUB, 32'd5, 32'd5);
        run_op("sll_31",    C_SLL, 32'd1, 32'd31);
        run_op("sra_4",     C_SRA, 32'h8000_0000, 32'd4);
        run_op("srl_sh0",   C_SRL, 32'hABCD_0000, 32'h0000_0020);
        run_op("srl_mask",  C_SRL, 32'hABCD_0000, 32'h0000_0021);
        run_op("sub_borrow",C_SUB, 32'd3, 32'd5);
        run_op("slt_neg",   C_SLT, 32'hFFFF_FFFF, 32'd1);
        run_op("slt_ovf",   C_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
        run_op("add_carry", C_ADD, 32'hFFFF_FFFF, 32'h2);
        run_op("and",       C_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        run_op("sll_2",     C_SLL, 32'hC000_0001, 32'd2);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom), $urandom, $urandom);
        end

        // Backpressure: result must hold and new requests must be ignored
        out_ready = 1'b0;
        send("bp_add", C_ADD, 32'd2, 32'd3);
        collect();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op = C_OR;
            a  = 32'hFFFF_0000;
            b  = 32'h0000_FFFF;
            step();
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready",  {63'd0, in_ready},  64'd0);
            check("bp_result",    {32'd0, result},    64'd5);
            check("bp_flags",     {60'd0, zflag, nflag, cflag, vflag}, 64'd0);
        end
        in_valid = 1'b0;
        release_result("bp");
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen = 1;
        end
        check("bp_no_phantom", 64'(seen), 64'd0);

        // Reset in the middle of a long shift discards it
        in_valid = 1'b1;
        op = C_SLL;
        a  = 32'd1;
        b  = 32'd20;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen = 1;
            step();
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        run_op("or_after_rst", C_OR, 32'h0000_00F0, 32'h0000_000F);
        check("or_after_rst_const", {32'd0, result}, 64'h0000_00FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire
